// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the transmit-arbiter state encoding.
// Used by uart_transmit, uart_receive and uart_tx_arbiter.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] ST_LOCKED    = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SEND      = ST_SEND,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE,
        LOCKED    = ST_LOCKED
    } arb_state_t;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set bit of req at or above ptr, wrapping; combinational, zero latency.
// No flow control; pick is one-hot or zero and found flags a non-empty req.
module rr_priority_select #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               found
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_rot;
    logic [NUM_REQ-1:0]   pick_rot;
    logic [2*NUM_REQ-1:0] pick_dbl;

    // Rotate so that bit 0 is the requester at ptr, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl  = {req, req};
        req_rot  = req_dbl >> ptr;
        pick_rot = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req_rot[i]) begin
                pick_rot[i] = 1'b1;
                found       = 1'b1;
            end
        end
        pick_dbl = {pick_rot, pick_rot} << ptr;
        pick     = pick_dbl[2*NUM_REQ-1:NUM_REQ];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart_transmit among NUM_REQ producers; frames hold the grant until last.
// Request sampled at t gives tx_send/req_ack at t+1; producers wait while tx_ready is low or another owns the grant.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 16,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ack,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           tx_send,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           err_timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMAX  = (BUSY_TIMEOUT > LOCK_TIMEOUT) ? BUSY_TIMEOUT : LOCK_TIMEOUT;
    localparam int TMR_W = $clog2(TMAX + 1);

    arb_state_t             state, state_nx;
    logic [PTR_W-1:0]       rr_ptr, rr_ptr_nx;
    logic [TMR_W-1:0]       timer;
    logic [NUM_REQ-1:0]     grant_q, grant_nx;
    logic [UART_DATA_W-1:0] data_q, data_nx;
    logic                   last_q, last_nx;
    logic                   err_q, err_nx;

    logic [NUM_REQ-1:0]     pick;
    logic                   found;
    logic [NUM_REQ-1:0]     src;
    logic [UART_DATA_W-1:0] sel_data;
    logic                   sel_last;
    logic [PTR_W-1:0]       g_idx;
    logic [PTR_W-1:0]       g_next;

    rr_priority_select #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_select (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .pick  (pick),
        .found (found)
    );

    // Byte source: the fresh round-robin pick when idle, the current owner when locked.
    always_comb begin
        src      = (state == LOCKED) ? grant_q : pick;
        sel_data = '0;
        sel_last = 1'b0;
        g_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src[i]) begin
                sel_data = req_data[UART_DATA_W*i +: UART_DATA_W];
                sel_last = req_last[i];
            end
            if (grant_q[i]) begin
                g_idx = PTR_W'(i);
            end
        end
        g_next = (g_idx == PTR_W'(NUM_REQ - 1)) ? '0 : g_idx + 1'b1;
    end

    always_comb begin
        state_nx  = state;
        rr_ptr_nx = rr_ptr;
        grant_nx  = grant_q;
        data_nx   = data_q;
        last_nx   = last_q;
        err_nx    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_ready && found) begin
                    grant_nx = pick;
                    data_nx  = sel_data;
                    last_nx  = sel_last;
                    state_nx = SEND;
                end
            end
            SEND: begin
                state_nx = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_nx = WAIT_DONE;
                end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    err_nx   = 1'b1;
                    state_nx = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_q) begin
                        rr_ptr_nx = g_next;
                        grant_nx  = '0;
                        state_nx  = IDLE;
                    end else begin
                        state_nx = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (|(req_valid & grant_q)) begin
                    data_nx  = sel_data;
                    last_nx  = sel_last;
                    state_nx = SEND;
                end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                    err_nx    = 1'b1;
                    rr_ptr_nx = g_next;
                    grant_nx  = '0;
                    state_nx  = IDLE;
                end
            end
            default: begin
                grant_nx = '0;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nx;
            rr_ptr  <= rr_ptr_nx;
            grant_q <= grant_nx;
            data_q  <= data_nx;
            last_q  <= last_nx;
            err_q   <= err_nx;
        end
    end

    // One counter serves both timeouts; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst || (state_nx != state)) begin
            timer <= '0;
        end else if (timer != '1) begin
            timer <= timer + 1'b1;
        end
    end

    assign tx_send     = (state == SEND);
    assign req_ack     = {NUM_REQ{tx_send}} & grant_q;
    assign grant       = grant_q;
    assign tx_data     = data_q;
    assign busy        = (state != IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural transmitter ready model and per-requester byte feeders.
module tb_uart_tx_arbiter;

    localparam int N        = 4;
    localparam int BUSY_CYC = 6;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           tx_send;
    logic [7:0]     tx_data;
    logic           tx_ready = 1'b1;
    logic           busy;
    logic           err_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (N),
        .BUSY_TIMEOUT (16),
        .LOCK_TIMEOUT (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ack     (req_ack),
        .grant       (grant),
        .tx_send     (tx_send),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic [7:0] b;
    } sb_t;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [7:0]  order;
        int          n;
    } vec_t;

    sb_t        sb[$];
    vec_t       vecs[6];

    logic [7:0] src_byte [N][4];
    logic       src_last [N][4];
    int         src_cnt  [N];
    int         src_pos  [N];

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   n_sent = 0;
    int   n_err = 0;
    int   last_send_cyc = 0;
    int   last_err_cyc = 0;
    int   inv_viol = 0;
    int   mode = 0;
    int   busy_cnt = 0;
    bit   prev_send = 1'b0;
    bit   inflight = 1'b0;
    logic [7:0] cur_byte = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor/scoreboard, ready model and requester feeders, all on the falling edge.
    initial begin
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_pos[i] = 0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                inflight  = 1'b0;
                prev_send = 1'b0;
            end else begin
                if (!$onehot0(grant)) inv_viol++;
                if (tx_send && prev_send) inv_viol++;
                prev_send = tx_send;
                if (inflight && !tx_ready && tx_data !== cur_byte) inv_viol++;
                if (err_timeout) begin
                    n_err++;
                    last_err_cyc = cyc;
                end
                if (tx_send) begin
                    n_sent++;
                    last_send_cyc = cyc;
                    cur_byte = tx_data;
                    inflight = 1'b1;
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_send: got byte %0h, none expected", tx_data);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        check("tx_data", {24'd0, tx_data}, {24'd0, e.b});
                        check("req_ack", {28'd0, req_ack}, 32'd1 << e.idx);
                        check("grant_at_send", {28'd0, grant}, 32'd1 << e.idx);
                    end
                end
            end
            if (mode == 2) begin
                busy_cnt = 0;
                tx_ready = 1'b0;
            end else if (mode == 1) begin
                busy_cnt = 0;
                tx_ready = 1'b1;
            end else if (tx_send && !rst) begin
                busy_cnt = BUSY_CYC;
                tx_ready = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_ready = 1'b1;
            end else begin
                tx_ready = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (req_ack[i] === 1'b1 && src_pos[i] < src_cnt[i]) src_pos[i]++;
                if (src_pos[i] < src_cnt[i]) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = src_byte[i][src_pos[i]];
                    req_last[i]        = src_last[i][src_pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int i, input logic [7:0] b, input logic l);
        src_byte[i][src_cnt[i]] = b;
        src_last[i][src_cnt[i]] = l;
        src_cnt[i]++;
    endtask

    task automatic expect_byte(input int i, input logic [7:0] b);
        sb_t e;
        e.idx = i;
        e.b   = b;
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            tick();
            done = (sb.size() == 0) && !busy && (req_valid == '0);
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s: drain timeout, got %0d bytes outstanding busy=%0b, required 0 and 0", name, sb.size(), busy);
        end
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_pos[i] = 0;
        end
    endtask

    task automatic wait_err(input string name, input int e0, input int budget);
        for (int k = 0; k < budget && n_err == e0; k++) tick();
        check({name, "_seen"}, n_err - e0, 1);
    endtask

    initial begin
        int base;
        int e0;
        int d;
        int viol;
        int idx;

        vecs[0] = '{4'b1111, 32'h44332211, 8'hE4, 4};
        vecs[1] = '{4'b0001, 32'h000000A5, 8'h00, 1};
        vecs[2] = '{4'b0010, 32'h00002200, 8'h01, 1};
        vecs[3] = '{4'b1111, 32'h44332211, 8'h4E, 4};
        vecs[4] = '{4'b1001, 32'hD30000D0, 8'h03, 2};
        vecs[5] = '{4'b0101, 32'h00C200C0, 8'h02, 2};

        rst = 1'b1;
        repeat (3) tick();
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_tx_send", {31'd0, tx_send}, 0);
        check("rst_req_ack", {28'd0, req_ack}, 0);
        check("rst_err", {31'd0, err_timeout}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        rst = 1'b0;
        tick();

        // Single-byte frames; expected grant order written out per vector.
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) begin
                if (vecs[v].valid[i]) load(i, vecs[v].data[8*i +: 8], 1'b1);
            end
            for (int k = 0; k < vecs[v].n; k++) begin
                idx = int'(vecs[v].order[2*k +: 2]);
                expect_byte(idx, vecs[v].data[8*idx +: 8]);
            end
            drain("vector", 300);
            check("vector_grant_idle", {28'd0, grant}, 0);
        end

        // Locked three-byte frame from req1 while req0 waits.
        load(1, 8'hB1, 1'b0);
        load(1, 8'hB2, 1'b0);
        load(1, 8'hB3, 1'b1);
        load(0, 8'h55, 1'b1);
        expect_byte(1, 8'hB1);
        expect_byte(1, 8'hB2);
        expect_byte(1, 8'hB3);
        expect_byte(0, 8'h55);
        base = n_sent;
        viol = 0;
        for (int k = 0; k < 20 && grant == '0; k++) tick();
        for (int k = 0; k < 300 && n_sent < base + 3; k++) begin
            if (grant !== 4'b0010) viol++;
            tick();
        end
        check("lock_frame_sends", n_sent - base, 3);
        check("lock_grant_held", viol, 0);
        drain("lock_frame", 300);

        // Transmitter never leaves ready: busy timeout, byte treated as sent.
        mode = 1;
        e0 = n_err;
        load(2, 8'h6B, 1'b1);
        expect_byte(2, 8'h6B);
        wait_err("busy_timeout", e0, 100);
        d = last_err_cyc - last_send_cyc;
        check("busy_timeout_delay_ok", (d == 16 || d == 17), 1);
        drain("busy_timeout", 100);
        mode = 0;
        tick();

        // Locked owner goes silent: lock timeout releases the grant.
        e0 = n_err;
        load(2, 8'h2C, 1'b0);
        expect_byte(2, 8'h2C);
        wait_err("lock_timeout", e0, 1200);
        d = last_err_cyc - last_send_cyc;
        check("lock_timeout_delay_ok", (d >= 1025 && d <= 1040), 1);
        check("lock_timeout_grant", {28'd0, grant}, 0);
        check("lock_timeout_busy", {31'd0, busy}, 0);
        drain("lock_timeout", 50);

        // Pointer moved past req2 after the revoke: order 3,0,2.
        load(0, 8'hA0, 1'b1);
        load(2, 8'hA2, 1'b1);
        load(3, 8'hA3, 1'b1);
        expect_byte(3, 8'hA3);
        expect_byte(0, 8'hA0);
        expect_byte(2, 8'hA2);
        drain("post_revoke", 300);

        // Reset while waiting for the transmitter mid-frame.
        load(1, 8'h77, 1'b0);
        expect_byte(1, 8'h77);
        base = n_sent;
        for (int k = 0; k < 50 && n_sent == base; k++) tick();
        check("mid_frame_sent", n_sent - base, 1);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_grant", {28'd0, grant}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        check("midrst_tx_send", {31'd0, tx_send}, 0);
        check("midrst_tx_data", {24'd0, tx_data}, 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_cnt[i] = 0;
            src_pos[i] = 0;
        end
        tick();
        load(1, 8'h99, 1'b1);
        load(3, 8'h9A, 1'b1);
        expect_byte(1, 8'h99);
        expect_byte(3, 8'h9A);
        drain("after_reset", 300);

        // No grant while the transmitter reports not ready.
        mode = 2;
        tick();
        tick();
        load(2, 8'h3C, 1'b1);
        expect_byte(2, 8'h3C);
        base = n_sent;
        repeat (10) tick();
        check("hold_no_send", n_sent - base, 0);
        check("hold_busy", {31'd0, busy}, 0);
        mode = 0;
        drain("hold_release", 100);

        check("invariants", inv_viol, 0);
        check("err_count", n_err, 2);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test, required finish before 500000");
        $fatal(1, "watchdog");
    end

endmodule
